// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Purpose  : Shared constants and types for the performance counter bank.
// Revision : 1.0
// ============================================================================
package perf_pkg;

  // Channel assignment used by the pipeline event wiring
  localparam int CH_TOTAL      = 0;
  localparam int CH_UNCOND     = 1;
  localparam int CH_COND       = 2;
  localparam int CH_COND_TAKEN = 3;

  localparam int CNT_W_DEFAULT = 32;

  typedef logic [CNT_W_DEFAULT-1:0] perf_cnt_t;

endpackage
`default_nettype wire

// File: rtl/perf_counter_ch.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_ch
// Purpose  : One event counter: edge/level detect, wrap or saturate, sticky ovf.
// Revision : 1.0
// ============================================================================
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             clr,
  input  logic             event_in,
  input  logic             edge_mode,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             prev_d;
  logic             prev_q;
  logic             inc;

  always_comb begin
    // History tracks the input even while halted, so halted edges are dropped
    prev_d = event_in;
    inc    = !halt && !clr && (edge_mode ? (event_in && !prev_q) : event_in);
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SAT != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      prev_q <= prev_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Purpose  : Bank of event counters with atomic snapshot and registered readout.
//            Optional threshold interrupt on channel 0 via PERF_CNT_IRQ_EN.
// Revision : 1.0
// ============================================================================
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int SAT    = 0,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              clr,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [NUM_CH-1:0] edge_mode,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
`ifdef PERF_CNT_IRQ_EN
  input  logic [CNT_W-1:0]  thresh,
  output logic              irq,
`endif
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              snap_done
);

  logic [CNT_W-1:0] cnt_w    [NUM_CH];
  logic [CNT_W-1:0] shadow_d [NUM_CH];
  logic [CNT_W-1:0] shadow_q [NUM_CH];
  logic [CNT_W-1:0] rd_data_d;
  logic [CNT_W-1:0] rd_data_q;
  logic             snap_done_d;
  logic             snap_done_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    perf_counter_ch #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .halt      (halt),
      .clr       (clr),
      .event_in  (event_in[gi]),
      .edge_mode (edge_mode[gi]),
      .cnt       (cnt_w[gi]),
      .ovf       (ovf[gi])
    );
  end

  // Shadows load the pre-edge live values; readout sees the old shadow this cycle
  always_comb begin
    snap_done_d = snap;
    rd_data_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = snap ? cnt_w[i] : shadow_q[i];
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
      rd_data_q   <= '0;
      snap_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      rd_data_q   <= rd_data_d;
      snap_done_q <= snap_done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign snap_done = snap_done_q;

`ifdef PERF_CNT_IRQ_EN
  logic [CNT_W-1:0] cnt0_last_d;
  logic [CNT_W-1:0] cnt0_last_q;
  logic             irq_d;
  logic             irq_q;

  // A change in cnt_0 that lands at or above thresh can only come from an increment
  always_comb begin
    cnt0_last_d = cnt_w[0];
    irq_d       = irq_q;
    if (clr) begin
      irq_d = 1'b0;
    end else if ((thresh != '0) && (cnt_w[0] != cnt0_last_q) && (cnt_w[0] >= thresh)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_last_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      cnt0_last_q <= cnt0_last_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
`default_nettype wire
